// File: rtl/mode_controller_pkg.sv
// Shared state encodings, song constants and one-hot key helpers for the piano mode sequencer.
package mode_controller_pkg;

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_SELECT = 2'd1,
        ST_RUN    = 2'd2,
        ST_LEARN  = 2'd3
    } state_t;

    localparam int unsigned SONG_NONE = 0;

    // Keys are at most 32 wide; callers zero-extend their key vector.
    function automatic logic key_onehot(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic int unsigned key_index(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) if (v[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/mode_controller_key_remap_table.sv
// Physical-to-logical key remap table with shadow copy, identity reset and combinational lookup.
module key_remap_table #(
    parameter int unsigned KEY_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             snap,
    input  logic             restore,
    input  logic             commit,
    input  logic             wr_en,
    input  logic [KEY_W-1:0] wr_sel,
    input  logic [KEY_W-1:0] wr_data,
    input  logic [KEY_W-1:0] note_key,
    output logic [KEY_W-1:0] remap_note
);

    logic [KEY_W-1:0] tbl     [KEY_W];
    logic [KEY_W-1:0] shadow  [KEY_W];
    logic [KEY_W-1:0] tbl_nxt [KEY_W];

    always_comb begin
        for (int unsigned k = 0; k < KEY_W; k++) begin
            tbl_nxt[k] = tbl[k];
            if (restore)
                tbl_nxt[k] = shadow[k];
            else if (wr_en && wr_sel[k])
                tbl_nxt[k] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < KEY_W; k++) begin
                tbl[k]    <= KEY_W'(1) << k;
                shadow[k] <= KEY_W'(1) << k;
            end
        end else begin
            for (int unsigned k = 0; k < KEY_W; k++) begin
                tbl[k] <= tbl_nxt[k];
                if (snap)
                    shadow[k] <= tbl[k];
                else if (commit)
                    shadow[k] <= tbl_nxt[k];
            end
        end
    end

    always_comb begin
        remap_note = '0;
        for (int unsigned k = 0; k < KEY_W; k++)
            if (note_key[k]) remap_note = remap_note | tbl[k];
    end

endmodule

// File: rtl/mode_controller.sv
// Top-level MENU/SELECT/RUN/LEARN sequencer with child output mux and key remap.
// Optional: define IDLE_TIMEOUT_EN to return to MENU after IDLE_CYCLES idle cycles in SELECT/LEARN.
module mode_controller
    import mode_controller_pkg::*;
#(
    parameter int unsigned           KEY_W       = 7,
    parameter int unsigned           TUBE_W      = 8,
    parameter int unsigned           NUM_MODES   = 4,
    parameter int unsigned           NUM_SONGS   = 3,
    parameter int unsigned           SONG_W      = 2,
    parameter logic [NUM_MODES-1:0]  NEEDS_SONG  = 4'b1110,
    parameter int unsigned           LEARN_IDX   = 4,
    parameter int unsigned           IDLE_CYCLES = 100_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        submit,
    input  logic                        cancel,
    input  logic [KEY_W-1:0]            note_key,
    output logic [KEY_W-1:0]            remap_note,
    output logic [NUM_MODES-1:0]        mode_en,
    output logic [SONG_W-1:0]           song_sel,
    output logic [1:0]                  state_o,
    input  logic [NUM_MODES*KEY_W-1:0]  child_led,
    input  logic [NUM_MODES-1:0]        child_buzzer,
    input  logic [NUM_MODES*TUBE_W-1:0] child_tube1,
    input  logic [NUM_MODES*TUBE_W-1:0] child_tube2,
    input  logic [NUM_MODES*TUBE_W-1:0] child_seg_en,
    input  logic [TUBE_W-1:0]           menu_tube1,
    input  logic [TUBE_W-1:0]           menu_tube2,
    input  logic [TUBE_W-1:0]           menu_seg_en,
    output logic [KEY_W-1:0]            led,
    output logic                        buzzer,
    output logic [TUBE_W-1:0]           tube1,
    output logic [TUBE_W-1:0]           tube2,
    output logic [TUBE_W-1:0]           seg_en
);

    localparam int unsigned IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    state_t             state_q, nxt_state;
    logic [IDX_W-1:0]   active_q, nxt_active;
    logic [IDX_W-1:0]   pending_q, nxt_pending;
    logic [SONG_W-1:0]  nxt_song;
    logic [CNT_W-1:0]   count_q, nxt_count;
    logic [KEY_W-1:0]   mask_q, nxt_mask;

    logic               sub_q1, sub_q2, can_q1, can_q2;
    logic               sub_p, can_p, cancel_now, submit_now, timeout;
    logic               key_ok;
    int unsigned        key_idx;

    logic               tbl_snap, tbl_restore, tbl_commit, tbl_wr;
    logic [KEY_W-1:0]   tbl_wr_data;

    logic [KEY_W-1:0]   nxt_led;
    logic               nxt_buzzer;
    logic [TUBE_W-1:0]  nxt_tube1, nxt_tube2, nxt_seg_en;
    logic [NUM_MODES-1:0] nxt_mode_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q1 <= 1'b0;
            sub_q2 <= 1'b0;
            can_q1 <= 1'b0;
            can_q2 <= 1'b0;
        end else begin
            sub_q1 <= submit;
            sub_q2 <= sub_q1;
            can_q1 <= cancel;
            can_q2 <= can_q1;
        end
    end

    assign sub_p   = sub_q1 & ~sub_q2;
    assign can_p   = can_q1 & ~can_q2;
    assign key_ok  = key_onehot(32'(note_key));
    assign key_idx = key_index(32'(note_key));

`ifdef IDLE_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q;
    logic              waiting;

    // Entry to SELECT/LEARN is always from MENU, where the counter is held at zero.
    assign waiting = (state_q == ST_SELECT) || (state_q == ST_LEARN);
    assign timeout = waiting && (idle_q == IDLE_W'(IDLE_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_q <= '0;
        else if (waiting && !sub_p && !timeout)
            idle_q <= idle_q + 1'b1;
        else
            idle_q <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    assign cancel_now = can_p | timeout;
    assign submit_now = sub_p & ~cancel_now & key_ok;

    always_comb begin
        nxt_state   = state_q;
        nxt_active  = active_q;
        nxt_pending = pending_q;
        nxt_song    = song_sel;
        nxt_count   = count_q;
        nxt_mask    = mask_q;
        tbl_snap    = 1'b0;
        tbl_restore = 1'b0;
        tbl_commit  = 1'b0;
        tbl_wr      = 1'b0;
        tbl_wr_data = '0;

        unique case (state_q)
            ST_MENU: begin
                if (submit_now) begin
                    if (key_idx < NUM_MODES) begin
                        if (NEEDS_SONG[key_idx]) begin
                            nxt_state   = ST_SELECT;
                            nxt_pending = IDX_W'(key_idx);
                        end else begin
                            nxt_state  = ST_RUN;
                            nxt_active = IDX_W'(key_idx);
                        end
                    end else if (key_idx == LEARN_IDX) begin
                        nxt_state = ST_LEARN;
                        tbl_snap  = 1'b1;
                        nxt_count = '0;
                        nxt_mask  = '0;
                    end
                end
            end
            ST_SELECT: begin
                if (cancel_now) begin
                    nxt_state = ST_MENU;
                    nxt_song  = SONG_W'(SONG_NONE);
                end else if (submit_now && key_idx < NUM_SONGS) begin
                    nxt_state  = ST_RUN;
                    nxt_song   = SONG_W'(key_idx + 1);
                    nxt_active = pending_q;
                end
            end
            ST_RUN: begin
                if (cancel_now) begin
                    nxt_state = ST_MENU;
                    nxt_song  = SONG_W'(SONG_NONE);
                end
            end
            ST_LEARN: begin
                if (cancel_now) begin
                    nxt_state   = ST_MENU;
                    tbl_restore = 1'b1;
                end else if (submit_now && !mask_q[key_idx]) begin
                    tbl_wr      = 1'b1;
                    tbl_wr_data = KEY_W'(1) << count_q;
                    nxt_mask    = mask_q | note_key;
                    nxt_count   = count_q + 1'b1;
                    if (count_q == CNT_W'(KEY_W - 1)) begin
                        nxt_state  = ST_MENU;
                        tbl_commit = 1'b1;
                    end
                end
            end
            default: nxt_state = ST_MENU;
        endcase
    end

    // Outputs are muxed from the next state so a transition and its outputs land on one edge.
    always_comb begin
        nxt_mode_en = '0;
        nxt_led     = '0;
        nxt_buzzer  = 1'b0;
        nxt_tube1   = menu_tube1;
        nxt_tube2   = menu_tube2;
        nxt_seg_en  = menu_seg_en;
        unique case (nxt_state)
            ST_RUN: begin
                nxt_mode_en = NUM_MODES'(1) << nxt_active;
                nxt_led     = child_led[nxt_active * KEY_W +: KEY_W];
                nxt_buzzer  = child_buzzer[nxt_active];
                nxt_tube1   = child_tube1[nxt_active * TUBE_W +: TUBE_W];
                nxt_tube2   = child_tube2[nxt_active * TUBE_W +: TUBE_W];
                nxt_seg_en  = child_seg_en[nxt_active * TUBE_W +: TUBE_W];
            end
            ST_SELECT: nxt_led = KEY_W'(1) << nxt_pending;
            ST_LEARN:  nxt_led = nxt_mask;
            default:   nxt_led = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_MENU;
            active_q  <= '0;
            pending_q <= '0;
            count_q   <= '0;
            mask_q    <= '0;
            song_sel  <= '0;
            mode_en   <= '0;
            led       <= '0;
            buzzer    <= 1'b0;
            tube1     <= '0;
            tube2     <= '0;
            seg_en    <= '0;
        end else begin
            state_q   <= nxt_state;
            active_q  <= nxt_active;
            pending_q <= nxt_pending;
            count_q   <= nxt_count;
            mask_q    <= nxt_mask;
            song_sel  <= nxt_song;
            mode_en   <= nxt_mode_en;
            led       <= nxt_led;
            buzzer    <= nxt_buzzer;
            tube1     <= nxt_tube1;
            tube2     <= nxt_tube2;
            seg_en    <= nxt_seg_en;
        end
    end

    assign state_o = state_q;

    key_remap_table #(
        .KEY_W (KEY_W)
    ) u_remap (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap       (tbl_snap),
        .restore    (tbl_restore),
        .commit     (tbl_commit),
        .wr_en      (tbl_wr),
        .wr_sel     (note_key),
        .wr_data    (tbl_wr_data),
        .note_key   (note_key),
        .remap_note (remap_note)
    );

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: directed scenarios plus randomized button/key traffic.
module tb_mode_controller;

    localparam int KEY_W     = 7;
    localparam int TUBE_W    = 8;
    localparam int NM        = 4;
    localparam int NS        = 3;
    localparam int SONG_W    = 2;
    localparam int LEARN_IDX = 4;
    localparam logic [3:0] NEEDS = 4'b1110;
`ifdef IDLE_TIMEOUT_EN
    localparam int IDLE = 16;
`else
    localparam int IDLE = 100_000_000;
`endif

    logic                     clk, rst_n, submit, cancel;
    logic [KEY_W-1:0]         note_key, remap_note, led;
    logic [NM-1:0]            mode_en, child_buzzer;
    logic [SONG_W-1:0]        song_sel;
    logic [1:0]               state_o;
    logic [NM*KEY_W-1:0]      child_led;
    logic [NM*TUBE_W-1:0]     child_tube1, child_tube2, child_seg_en;
    logic [TUBE_W-1:0]        menu_tube1, menu_tube2, menu_seg_en, tube1, tube2, seg_en;
    logic                     buzzer;

    mode_controller #(
        .KEY_W(KEY_W), .TUBE_W(TUBE_W), .NUM_MODES(NM), .NUM_SONGS(NS), .SONG_W(SONG_W),
        .NEEDS_SONG(NEEDS), .LEARN_IDX(LEARN_IDX), .IDLE_CYCLES(IDLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .submit(submit), .cancel(cancel), .note_key(note_key),
        .remap_note(remap_note), .mode_en(mode_en), .song_sel(song_sel), .state_o(state_o),
        .child_led(child_led), .child_buzzer(child_buzzer), .child_tube1(child_tube1),
        .child_tube2(child_tube2), .child_seg_en(child_seg_en), .menu_tube1(menu_tube1),
        .menu_tube2(menu_tube2), .menu_seg_en(menu_seg_en), .led(led), .buzzer(buzzer),
        .tube1(tube1), .tube2(tube2), .seg_en(seg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, 0=MENU 1=SELECT 2=RUN 3=LEARN.
    int m_st, m_act, m_pend, m_song, m_cnt, m_mask;
    int m_tbl[KEY_W];
    int m_shadow[KEY_W];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input int v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int exp_remap(input int key);
        int r = 0;
        for (int k = 0; k < KEY_W; k++) if (((key >> k) & 1) != 0) r |= m_tbl[k];
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_act = 0; m_pend = 0; m_song = 0; m_cnt = 0; m_mask = 0;
        for (int k = 0; k < KEY_W; k++) begin
            m_tbl[k] = 1 << k;
            m_shadow[k] = 1 << k;
        end
    endtask

    task automatic model_step(input bit s, input bit c, input int key);
        bit valid;
        int idx;
        valid = (popc(key) == 1);
        idx = 0;
        for (int i = 0; i < KEY_W; i++) if (((key >> i) & 1) != 0) idx = i;
        if (c) begin
            if (m_st == 1 || m_st == 2) begin
                m_st = 0; m_song = 0;
            end else if (m_st == 3) begin
                m_tbl = m_shadow; m_st = 0;
            end
        end else if (s && valid) begin
            case (m_st)
                0: if (idx < NM) begin
                       if (NEEDS[idx]) begin m_st = 1; m_pend = idx; end
                       else begin m_st = 2; m_act = idx; end
                   end else if (idx == LEARN_IDX) begin
                       m_shadow = m_tbl; m_cnt = 0; m_mask = 0; m_st = 3;
                   end
                1: if (idx < NS) begin m_song = idx + 1; m_act = m_pend; m_st = 2; end
                3: if (((m_mask >> idx) & 1) == 0) begin
                       m_tbl[idx] = 1 << m_cnt;
                       m_mask |= 1 << idx;
                       m_cnt++;
                       if (m_cnt == KEY_W) m_st = 0;
                   end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string ctx);
        int e_led;
        logic [TUBE_W-1:0] e_t1, e_t2, e_se;
        logic e_bz;
        e_led = 0; e_bz = 1'b0;
        e_t1 = menu_tube1; e_t2 = menu_tube2; e_se = menu_seg_en;
        case (m_st)
            1: e_led = 1 << m_pend;
            2: begin
                   e_led = int'(child_led >> (m_act * KEY_W)) & 'h7f;
                   e_bz  = child_buzzer[m_act];
                   e_t1  = TUBE_W'(child_tube1 >> (m_act * TUBE_W));
                   e_t2  = TUBE_W'(child_tube2 >> (m_act * TUBE_W));
                   e_se  = TUBE_W'(child_seg_en >> (m_act * TUBE_W));
               end
            3: e_led = m_mask;
            default: ;
        endcase
        chk({ctx, ".state"},   64'(state_o),  64'(m_st));
        chk({ctx, ".mode_en"}, 64'(mode_en),  (m_st == 2) ? 64'(1 << m_act) : 64'd0);
        chk({ctx, ".song"},    64'(song_sel), 64'(m_song));
        chk({ctx, ".led"},     64'(led),      64'(e_led));
        chk({ctx, ".buzzer"},  64'(buzzer),   64'(e_bz));
        chk({ctx, ".tube1"},   64'(tube1),    64'(e_t1));
        chk({ctx, ".tube2"},   64'(tube2),    64'(e_t2));
        chk({ctx, ".seg_en"},  64'(seg_en),   64'(e_se));
    endtask

    task automatic drive_env(input int key);
        @(negedge clk);
        child_led    = {$urandom, $urandom};
        child_buzzer = NM'($urandom);
        child_tube1  = $urandom;
        child_tube2  = $urandom;
        child_seg_en = $urandom;
        menu_tube1   = TUBE_W'($urandom);
        menu_tube2   = TUBE_W'($urandom);
        menu_seg_en  = TUBE_W'($urandom);
        note_key     = KEY_W'(key);
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit c);
        @(negedge clk);
        submit = s; cancel = c;
        repeat (3) @(negedge clk);
        submit = 1'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        model_step(s, c, int'(note_key));
    endtask

    task automatic step(input string ctx, input int key, input bit s, input bit c);
        drive_env(key);
        press(s, c);
        check_all(ctx);
    endtask

    initial begin
        int key, r;
        submit = 0; cancel = 0; note_key = '0; rst_n = 0;
        child_led = '0; child_buzzer = '0; child_tube1 = '0; child_tube2 = '0;
        child_seg_en = '0; menu_tube1 = '0; menu_tube2 = '0; menu_seg_en = '0;
        model_reset();
        repeat (3) @(negedge clk);
        note_key = 7'b0001000;
        #1;
        chk("reset.state", 64'(state_o), 64'd0);
        chk("reset.mode_en", 64'(mode_en), 64'd0);
        chk("reset.led", 64'(led), 64'd0);
        chk("reset.tube1", 64'(tube1), 64'd0);
        chk("reset.remap", 64'(remap_note), 64'h08);
        rst_n = 1;

        // Mode 0 runs without song selection; its LED slice is forwarded.
        drive_env(7'b0000001);
        child_led[6:0] = 7'h55;
        press(1, 0);
        check_all("mode0");
        chk("mode0.led55", 64'(led), 64'h55);
        step("mode0.exit", 7'b0000001, 0, 1);

        step("sel.enter", 7'b0000010, 1, 0);
        chk("sel.led", 64'(led), 64'h02);
        step("sel.song3", 7'b0000100, 1, 0);
        chk("sel.song_sel", 64'(song_sel), 64'd3);
        chk("sel.mode_en", 64'(mode_en), 64'h2);
        step("sel.cancel", 7'b0000100, 0, 1);
        chk("sel.cancel_mode_en", 64'(mode_en), 64'd0);

        // Partial learn then cancel must leave the identity table.
        step("plearn.enter", 7'b0010000, 1, 0);
        step("plearn.k6", 7'b1000000, 1, 0);
        step("plearn.k5", 7'b0100000, 1, 0);
        step("plearn.k4", 7'b0010000, 1, 0);
        step("plearn.cancel", 7'b0001000, 0, 1);
        #1 chk("plearn.remap", 64'(remap_note), 64'h08);

        // Full learn in reverse order with a repeated key mid-sequence.
        step("learn.enter", 7'b0010000, 1, 0);
        for (int k = 6; k >= 0; k--) begin
            step("learn.key", 1 << k, 1, 0);
            if (k == 4) step("learn.repeat6", 7'b1000000, 1, 0);
        end
        chk("learn.done_state", 64'(state_o), 64'd0);
        note_key = 7'b1000000;
        #1 chk("learn.remap6", 64'(remap_note), 64'h01);
        for (int k = 0; k < 16; k++) begin
            note_key = KEY_W'($urandom);
            #1 chk("learn.remap_rand", 64'(remap_note), 64'(exp_remap(int'(note_key))));
        end

        step("both.enter", 7'b0000010, 1, 0);
        step("both.cancel_wins", 7'b0000001, 1, 1);
        step("multihot", 7'b0000011, 1, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 7) key = 1 << $urandom_range(0, KEY_W - 1);
            else key = $urandom_range(0, 127);
            r = $urandom_range(0, 19);
`ifdef IDLE_TIMEOUT_EN
            if (r >= 15) r = 0;
`endif
            drive_env(key);
            #1 chk("rand.remap", 64'(remap_note), 64'(exp_remap(key)));
            if (r < 10)      press(1, 0);
            else if (r < 14) press(0, 1);
            else if (r < 15) press(1, 1);
            else             press(0, 0);
            check_all("rand");
        end

        // Asynchronous reset in the middle of LEARN.
        step("areset.menu", 7'b0000001, 0, 1);
        step("areset.enter", 7'b0010000, 1, 0);
        step("areset.k0", 7'b0000001, 1, 0);
        step("areset.k1", 7'b0000010, 1, 0);
        note_key = 7'b0000001;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("areset.state", 64'(state_o), 64'd0);
        chk("areset.led", 64'(led), 64'd0);
        chk("areset.buzzer", 64'(buzzer), 64'd0);
        chk("areset.tubes", 64'({tube1, tube2, seg_en}), 64'd0);
        chk("areset.song", 64'(song_sel), 64'd0);
        chk("areset.remap", 64'(remap_note), 64'h01);
        @(negedge clk);
        rst_n = 1;

`ifdef IDLE_TIMEOUT_EN
        step("idle.enter", 7'b0000010, 1, 0);
        repeat (8) @(negedge clk);
        chk("idle.still_select", 64'(state_o), 64'd1);
        repeat (12) @(negedge clk);
        model_step(0, 1, 0);
        check_all("idle.timeout");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
